// File: rtl/y86_pipe_stage_reg_pkg.sv
// Shared Y86 pipeline-stage types: packed stage payload, bubble constants and skid FSM states.
// Each stage register carries the same payload layout; a stage's bubble value is its NOP packing.
package y86_pipe_stage_reg_pkg;

    localparam logic [3:0] I_NOP = 4'h1;
    localparam logic [3:0] RNONE = 4'hf;
    localparam logic [2:0] SAOK  = 3'd1;

    // rsvd pads the field sum out to the 218-bit bus shared by every stage
    typedef struct packed {
        logic [5:0]  rsvd;
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HALF,
        ST_FULL
    } skid_state_e;

    function automatic stage_t bubble_pkt(input logic [63:0] pc);
        stage_t s;
        s       = '0;
        s.stat  = SAOK;
        s.pc    = pc;
        s.icode = I_NOP;
        s.dst_e = RNONE;
        s.dst_m = RNONE;
        return s;
    endfunction

    localparam stage_t STAGE_BUBBLE = bubble_pkt(64'h0);
    localparam stage_t F_BUBBLE = STAGE_BUBBLE, D_BUBBLE = STAGE_BUBBLE, E_BUBBLE = STAGE_BUBBLE,
                       M_BUBBLE = STAGE_BUBBLE, W_BUBBLE = STAGE_BUBBLE;

endpackage

// File: rtl/y86_pipe_stage_reg_if.sv
// Stage-register bus: upstream payload/handshake, downstream payload/handshake, control and status.
// master = surrounding pipeline, slave = the stage register.
interface y86_pipe_stage_reg_if
    import y86_pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = STAGE_W,
    parameter int CNT_W  = 16
);
    logic              stall_i;
    logic              bubble_i;
    logic [DATA_W-1:0] d_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] q_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic              ctl_err_o;

    modport master (
        output stall_i, bubble_i, d_i, in_valid_i, out_ready_i,
        input  in_ready_o, q_o, out_valid_o, stall_cnt_o, bubble_cnt_o, ctl_err_o
    );

    modport slave (
        input  stall_i, bubble_i, d_i, in_valid_i, out_ready_i,
        output in_ready_o, q_o, out_valid_o, stall_cnt_o, bubble_cnt_o, ctl_err_o
    );
endinterface

// File: rtl/y86_pipe_stage_reg_skid_buf.sv
// Two-entry elastic stage (head + skid) with EMPTY/HALF/FULL FSM; 1-cycle latency, 1 beat/cycle.
// Backpressure: in_ready_o is registered and drops only in FULL; flush_i empties both entries and drops the input beat.
module y86_pipe_stage_reg_skid_buf
    import y86_pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = STAGE_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] q_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);
    skid_state_e       state_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_rdy_q;
    logic              out_vld_q;
    logic              xfer_in;
    logic              xfer_out;

    assign xfer_in     = in_valid_i && in_rdy_q;
    assign xfer_out    = out_vld_q && out_ready_i;
    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign q_o         = head_q;

    // handshake flags are updated alongside the state so they always equal (state!=FULL)/(state!=EMPTY)
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            state_q   <= ST_EMPTY;
            head_q    <= BUBBLE_VAL;
            skid_q    <= BUBBLE_VAL;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        head_q    <= d_i;
                        state_q   <= ST_HALF;
                        out_vld_q <= 1'b1;
                    end
                end
                ST_HALF: begin
                    if (xfer_in && !xfer_out) begin
                        skid_q   <= d_i;
                        state_q  <= ST_FULL;
                        in_rdy_q <= 1'b0;
                    end else if (xfer_out && !xfer_in) begin
                        state_q   <= ST_EMPTY;
                        out_vld_q <= 1'b0;
                    end else if (xfer_in && xfer_out) begin
                        head_q <= d_i;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        head_q   <= skid_q;
                        state_q  <= ST_HALF;
                        in_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_EMPTY;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Y86 pipeline-stage register: MODE 0 stall/bubble register, MODE 1 elastic 2-entry stage; 1-cycle latency.
// Backpressure: MODE 0 holds on stall_i (in_ready_o = !stall_i); MODE 1 uses valid/ready with a skid entry.
module y86_pipe_stage_reg
    import y86_pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = STAGE_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                MODE       = 0,
    parameter int                CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    y86_pipe_stage_reg_if.slave bus
);
    logic             stall_ev;
    logic             err_ev;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             ctl_err_q;

    generate
        if (MODE == 0) begin : g_stall_bubble
            logic [DATA_W-1:0] q_q;
            logic              vld_q;
            logic              unused_elastic;

            // bubble beats stall beats load
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    q_q   <= BUBBLE_VAL;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= 1'b1;
                    if (bus.bubble_i) begin
                        q_q <= BUBBLE_VAL;
                    end else if (!bus.stall_i) begin
                        q_q <= bus.d_i;
                    end
                end
            end

            assign bus.q_o         = q_q;
            assign bus.out_valid_o = vld_q;
            assign bus.in_ready_o  = !bus.stall_i;
            assign stall_ev        = bus.stall_i;
            assign err_ev          = bus.stall_i && bus.bubble_i;
            assign unused_elastic  = bus.in_valid_i ^ bus.out_ready_i;
        end else begin : g_elastic
            logic unused_stall;

            y86_pipe_stage_reg_skid_buf #(
                .DATA_W     (DATA_W),
                .BUBBLE_VAL (BUBBLE_VAL)
            ) u_skid (
                .clk_i       (clk_i),
                .rst_n_i     (rst_n_i),
                .flush_i     (bus.bubble_i),
                .d_i         (bus.d_i),
                .in_valid_i  (bus.in_valid_i),
                .in_ready_o  (bus.in_ready_o),
                .q_o         (bus.q_o),
                .out_valid_o (bus.out_valid_o),
                .out_ready_i (bus.out_ready_i)
            );

            assign stall_ev     = bus.out_valid_o && !bus.out_ready_i;
            assign err_ev       = 1'b0;
            assign unused_stall = bus.stall_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            ctl_err_q    <= 1'b0;
        end else begin
            if (stall_ev && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.bubble_i && !(&bubble_cnt_q)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
            if (err_ev) begin
                ctl_err_q <= 1'b1;
            end
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.ctl_err_o    = ctl_err_q;
endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Bench for y86_pipe_stage_reg: MODE 0 instance (CNT_W=4) and MODE 1 instance (CNT_W=16) on one clock.
module tb_y86_pipe_stage_reg;
    import y86_pipe_stage_reg_pkg::*;

    localparam int             DW = STAGE_W;
    localparam logic [DW-1:0]  BV = STAGE_BUBBLE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    y86_pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(4))  b0 ();
    y86_pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) b1 ();

    y86_pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BV), .MODE(0), .CNT_W(4)) u_m0 (
        .clk_i (clk), .rst_n_i (rst_n), .bus (b0)
    );
    y86_pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BV), .MODE(1), .CNT_W(16)) u_m1 (
        .clk_i (clk), .rst_n_i (rst_n), .bus (b1)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    logic [DW-1:0] m0_q;

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        logic [223:0] t;
        t = {28{b}};
        return t[DW-1:0];
    endfunction

    task automatic idle_inputs();
        b0.d_i = '0; b0.stall_i = 1'b0; b0.bubble_i = 1'b0; b0.in_valid_i = 1'b0; b0.out_ready_i = 1'b0;
        b1.d_i = '0; b1.stall_i = 1'b0; b1.bubble_i = 1'b0; b1.in_valid_i = 1'b0; b1.out_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb0.delete();
        sb1.delete();
        m0_q = BV;
    endtask

    // drives one MODE 0 cycle and queues the value q_o must show after the next edge
    task automatic m0_cycle(input logic [DW-1:0] d, input logic st, input logic bb);
        b0.d_i = d; b0.stall_i = st; b0.bubble_i = bb;
        if (bb) m0_q = BV;
        else if (!st) m0_q = d;
        sb0.push_back(m0_q);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        b0.stall_i = 1'b1; b0.bubble_i = 1'b1; b1.in_valid_i = 1'b1; b1.d_i = pat(8'hEE);
        @(negedge clk);
        @(negedge clk);
        checks++; if (b0.q_o !== BV) begin failures++; $display("FAIL rst_m0_q got=%h exp=%h", b0.q_o, BV); end
        checks++; if (b0.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_m0_vld got=%b exp=0", b0.out_valid_o); end
        checks++; if (b0.stall_cnt_o !== 4'd0 || b0.bubble_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_m0_cnt got=%0d/%0d exp=0/0", b0.stall_cnt_o, b0.bubble_cnt_o); end
        checks++; if (b0.ctl_err_o !== 1'b0) begin failures++; $display("FAIL rst_m0_err got=%b exp=0", b0.ctl_err_o); end
        checks++; if (b1.q_o !== BV) begin failures++; $display("FAIL rst_m1_q got=%h exp=%h", b1.q_o, BV); end
        checks++; if (b1.out_valid_o !== 1'b0 || b1.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_m1_hs got vld=%b rdy=%b exp vld=0 rdy=1", b1.out_valid_o, b1.in_ready_o); end
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (b0.out_valid_o !== 1'b1) begin failures++; $display("FAIL m0_vld_after_rst got=%b exp=1", b0.out_valid_o); end
    endtask

    task automatic test_m0_load();
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m0_cycle(pat(8'hA5 + 8'(i)), 1'b0, 1'b0);
            exp = sb0.pop_front();
            checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_load[%0d] got=%h exp=%h", i, b0.q_o, exp); end
        end
        checks++; if (b0.stall_cnt_o !== 4'd0 || b0.bubble_cnt_o !== 4'd0) begin failures++; $display("FAIL m0_load_cnt got=%0d/%0d exp=0/0", b0.stall_cnt_o, b0.bubble_cnt_o); end
    endtask

    task automatic test_m0_stall_bubble();
        logic [DW-1:0] exp;
        stage_t        s;
        do_reset();
        m0_cycle(pat(8'h11), 1'b0, 1'b0);
        exp = sb0.pop_front();
        checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_sb_load got=%h exp=%h", b0.q_o, exp); end
        for (int i = 0; i < 2; i++) begin
            m0_cycle(pat(8'h22), 1'b1, 1'b0);
            exp = sb0.pop_front();
            checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_stall_hold[%0d] got=%h exp=%h", i, b0.q_o, exp); end
        end
        checks++; if (b0.in_ready_o !== 1'b0) begin failures++; $display("FAIL m0_stall_rdy got=%b exp=0", b0.in_ready_o); end
        checks++; if (b0.stall_cnt_o !== 4'd2) begin failures++; $display("FAIL m0_stall_cnt got=%0d exp=2", b0.stall_cnt_o); end
        m0_cycle(pat(8'h33), 1'b0, 1'b1);
        exp = sb0.pop_front();
        checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_bubble_q got=%h exp=%h", b0.q_o, exp); end
        s = b0.q_o;
        checks++; if (s.icode !== I_NOP || s.dst_e !== RNONE || s.dst_m !== RNONE) begin failures++; $display("FAIL m0_bubble_fields got icode=%h dstE=%h dstM=%h exp 1/f/f", s.icode, s.dst_e, s.dst_m); end
        checks++; if (b0.bubble_cnt_o !== 4'd1 || b0.stall_cnt_o !== 4'd2) begin failures++; $display("FAIL m0_bubble_cnt got=%0d/%0d exp=1/2", b0.bubble_cnt_o, b0.stall_cnt_o); end
        checks++; if (b0.ctl_err_o !== 1'b0) begin failures++; $display("FAIL m0_sb_err got=%b exp=0", b0.ctl_err_o); end
    endtask

    task automatic test_m0_conflict();
        logic [DW-1:0] exp;
        do_reset();
        m0_cycle(pat(8'h44), 1'b0, 1'b0);
        exp = sb0.pop_front();
        checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_cf_load got=%h exp=%h", b0.q_o, exp); end
        m0_cycle(pat(8'h55), 1'b1, 1'b1);
        exp = sb0.pop_front();
        checks++; if (b0.q_o !== exp) begin failures++; $display("FAIL m0_cf_q got=%h exp=%h", b0.q_o, exp); end
        checks++; if (b0.ctl_err_o !== 1'b1) begin failures++; $display("FAIL m0_cf_err got=%b exp=1", b0.ctl_err_o); end
        checks++; if (b0.stall_cnt_o !== 4'd1 || b0.bubble_cnt_o !== 4'd1) begin failures++; $display("FAIL m0_cf_cnt got=%0d/%0d exp=1/1", b0.stall_cnt_o, b0.bubble_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            m0_cycle(pat(8'h60 + 8'(i)), 1'b0, 1'b0);
            exp = sb0.pop_front();
            checks++; if (b0.q_o !== exp || b0.ctl_err_o !== 1'b1) begin failures++; $display("FAIL m0_cf_sticky[%0d] got q=%h err=%b exp q=%h err=1", i, b0.q_o, b0.ctl_err_o, exp); end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (b0.ctl_err_o !== 1'b0) begin failures++; $display("FAIL m0_cf_err_rst got=%b exp=0", b0.ctl_err_o); end
        rst_n = 1'b1;
    endtask

    // elastic stream against an occupancy model; rdy_from delays out_ready, rnd randomises both sides
    task automatic test_m1_stream(input string tag, input int n, input int rdy_from, input bit rnd,
                                  output int first_full_acc, output int cycles);
        int            nxt, got, cnt_m, stall_m, cyc;
        bit            vin, rdy, acc_in, acc_out;
        logic [DW-1:0] exp;
        do_reset();
        nxt = 0; got = 0; cnt_m = 0; stall_m = 0; cyc = 0; first_full_acc = -1;
        while (got < n && cyc < 2000) begin
            vin = (nxt < n) && (!rnd || $urandom_range(0, 3) != 0);
            rdy = (cyc >= rdy_from) && (!rnd || $urandom_range(0, 2) != 0);
            b1.in_valid_i = vin; b1.d_i = pat(8'(nxt + 1)); b1.out_ready_i = rdy;
            checks++; if (b1.in_ready_o !== (cnt_m != 2)) begin failures++; $display("FAIL %s_in_ready cyc=%0d got=%b exp=%b", tag, cyc, b1.in_ready_o, cnt_m != 2); end
            checks++; if (b1.out_valid_o !== (cnt_m != 0)) begin failures++; $display("FAIL %s_out_valid cyc=%0d got=%b exp=%b", tag, cyc, b1.out_valid_o, cnt_m != 0); end
            if (b1.in_ready_o === 1'b0 && first_full_acc < 0) first_full_acc = nxt;
            acc_in  = vin && (cnt_m != 2);
            acc_out = rdy && (cnt_m != 0);
            if (acc_out) begin
                checks++;
                if (sb1.size() == 0) begin
                    failures++; $display("FAIL %s_extra_beat cyc=%0d got=%h exp=none", tag, cyc, b1.q_o);
                end else begin
                    exp = sb1.pop_front();
                    if (b1.q_o !== exp) begin failures++; $display("FAIL %s_order cyc=%0d got=%h exp=%h", tag, cyc, b1.q_o, exp); end
                end
                got++;
            end
            if (acc_in) begin
                sb1.push_back(pat(8'(nxt + 1)));
                nxt++;
            end
            if (cnt_m != 0 && !rdy) stall_m++;
            cnt_m = cnt_m + int'(acc_in) - int'(acc_out);
            cyc++;
            @(negedge clk);
        end
        cycles = cyc;
        idle_inputs();
        checks++; if (got != n) begin failures++; $display("FAIL %s_timeout got=%0d beats exp=%0d", tag, got, n); end
        checks++; if (b1.stall_cnt_o !== 16'(stall_m)) begin failures++; $display("FAIL %s_stall_cnt got=%0d exp=%0d", tag, b1.stall_cnt_o, stall_m); end
    endtask

    task automatic test_m1_backpressure();
        int ff, cyc;
        test_m1_stream("m1_bp", 4, 6, 1'b0, ff, cyc);
        checks++; if (ff != 2) begin failures++; $display("FAIL m1_bp_full_after got=%0d beats exp=2", ff); end
    endtask

    task automatic test_back_to_back();
        int ff, cyc;
        test_m1_stream("m1_b2b", 8, 0, 1'b0, ff, cyc);
        checks++; if (cyc != 9) begin failures++; $display("FAIL m1_b2b_cycles got=%0d exp=9", cyc); end
        checks++; if (ff != -1) begin failures++; $display("FAIL m1_b2b_ready_drop got=%0d exp=-1", ff); end
    endtask

    task automatic test_m1_random();
        int ff, cyc;
        test_m1_stream("m1_rnd", 40, 0, 1'b1, ff, cyc);
    endtask

    task automatic test_m1_flush();
        logic [DW-1:0] exp;
        do_reset();
        b1.out_ready_i = 1'b0; b1.in_valid_i = 1'b1;
        b1.d_i = pat(8'hA1); sb1.push_back(pat(8'hA1)); @(negedge clk);
        b1.d_i = pat(8'hA2); sb1.push_back(pat(8'hA2)); @(negedge clk);
        checks++; if (b1.in_ready_o !== 1'b0 || b1.q_o !== sb1[0]) begin failures++; $display("FAIL m1_fl_full got rdy=%b q=%h exp rdy=0 q=%h", b1.in_ready_o, b1.q_o, sb1[0]); end
        b1.d_i = pat(8'hA3); b1.bubble_i = 1'b1; sb1.delete();
        @(negedge clk);
        b1.bubble_i = 1'b0; b1.in_valid_i = 1'b0; b1.out_ready_i = 1'b1;
        checks++; if (b1.out_valid_o !== 1'b0 || b1.in_ready_o !== 1'b1) begin failures++; $display("FAIL m1_fl_empty got vld=%b rdy=%b exp vld=0 rdy=1", b1.out_valid_o, b1.in_ready_o); end
        checks++; if (b1.q_o !== BV) begin failures++; $display("FAIL m1_fl_q got=%h exp=%h", b1.q_o, BV); end
        checks++; if (b1.bubble_cnt_o !== 16'd1) begin failures++; $display("FAIL m1_fl_cnt got=%0d exp=1", b1.bubble_cnt_o); end
        @(negedge clk);
        checks++; if (b1.out_valid_o !== 1'b0) begin failures++; $display("FAIL m1_fl_drop got vld=%b exp=0", b1.out_valid_o); end
        b1.in_valid_i = 1'b1; b1.d_i = pat(8'hA4); sb1.push_back(pat(8'hA4));
        @(negedge clk);
        b1.in_valid_i = 1'b0;
        exp = sb1.pop_front();
        checks++; if (b1.out_valid_o !== 1'b1 || b1.q_o !== exp) begin failures++; $display("FAIL m1_fl_next got vld=%b q=%h exp vld=1 q=%h", b1.out_valid_o, b1.q_o, exp); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [DW-1:0] exp;
        int            exp_cnt;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            m0_cycle(pat(8'(i + 1)), 1'b1, 1'b0);
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            exp = sb0.pop_front();
            checks++; if (b0.stall_cnt_o !== 4'(exp_cnt) || b0.q_o !== exp) begin failures++; $display("FAIL sat[%0d] got cnt=%0d q=%h exp cnt=%0d q=%h", i, b0.stall_cnt_o, b0.q_o, exp_cnt, exp); end
        end
        checks++; if (b0.stall_cnt_o !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", b0.stall_cnt_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b1.in_valid_i = 1'b1; b1.out_ready_i = 1'b0; b1.d_i = pat(8'h90);
        m0_cycle(pat(8'h77), 1'b0, 1'b0);
        m0_cycle(pat(8'h78), 1'b1, 1'b0);
        m0_cycle(pat(8'h79), 1'b1, 1'b1);
        checks++; if (b0.ctl_err_o !== 1'b1 || b1.in_ready_o !== 1'b0) begin failures++; $display("FAIL mid_pre got err=%b rdy=%b exp err=1 rdy=0", b0.ctl_err_o, b1.in_ready_o); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (b0.q_o !== BV || b0.out_valid_o !== 1'b0 || b0.ctl_err_o !== 1'b0) begin failures++; $display("FAIL mid_m0 got q=%h vld=%b err=%b exp q=%h vld=0 err=0", b0.q_o, b0.out_valid_o, b0.ctl_err_o, BV); end
        checks++; if (b0.stall_cnt_o !== 4'd0 || b0.bubble_cnt_o !== 4'd0) begin failures++; $display("FAIL mid_m0_cnt got=%0d/%0d exp=0/0", b0.stall_cnt_o, b0.bubble_cnt_o); end
        checks++; if (b1.q_o !== BV || b1.out_valid_o !== 1'b0 || b1.in_ready_o !== 1'b1) begin failures++; $display("FAIL mid_m1 got q=%h vld=%b rdy=%b exp q=%h vld=0 rdy=1", b1.q_o, b1.out_valid_o, b1.in_ready_o, BV); end
        checks++; if (b1.stall_cnt_o !== 16'd0 || b1.bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL mid_m1_cnt got=%0d/%0d exp=0/0", b1.stall_cnt_o, b1.bubble_cnt_o); end
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_q = BV;
        test_reset();
        test_m0_load();
        test_m0_stall_bubble();
        test_m0_conflict();
        test_m1_backpressure();
        test_back_to_back();
        test_m1_random();
        test_m1_flush();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
